fp_mult_core: RTL

- Sequential single-precision IEEE-754 multiplier datapath. It sits directly downstream of the FPU's special-case multiply detector.
- The detector's is_special/result pair is consumed here. Special operands bypass the datapath.
- All other operands go through an iterative 24x24 shift-add mantissa multiply, exponent add, normalise and truncate. The block uses a start/done handshake toward the FPU control.

---
 rtl/fp_mult_core.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fp_mult_core.sv
// Iterative IEEE-754 single-precision multiplier: special-case bypass or a
// 24-cycle shift-add mantissa multiply, then one normalise/truncate cycle.
module fp_mult_core #(
    parameter int MANT_W   = 24,
    parameter int EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        is_special,
    input  logic [31:0] special_result,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    // Handshake: start is sampled only in IDLE together with the operands and
    // the special flag; while busy it is ignored. done pulses for one cycle
    // with result valid in that cycle, and result is held until the next done.
    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t state, state_nxt;

    logic                  sign_r;
    logic signed [9:0]     exp_sum_r;
    logic [2*MANT_W-1:0]   mcand_r;
    logic [2*MANT_W-1:0]   prod_r;
    logic [MANT_W-1:0]     mplier_r;
    logic [4:0]            cnt_r;
    logic [31:0]           result_r;

    logic [7:0]            exp_a, exp_b;
    logic [MANT_W-1:0]     mant_a, mant_b;
    logic signed [9:0]     exp_sum_w;
    logic signed [9:0]     exp_norm;
    logic [MANT_W-2:0]     mant_norm;
    logic [31:0]           norm_result;

    assign exp_a  = operand_a[30:23];
    assign exp_b  = operand_b[30:23];
    assign mant_a = {exp_a != 8'd0, operand_a[22:0]};
    assign mant_b = {exp_b != 8'd0, operand_b[22:0]};

    // Range -127..383 fits 10-bit two's complement, so modular add is exact.
    assign exp_sum_w = $signed({2'b00, exp_a} + {2'b00, exp_b} - 10'(EXP_BIAS));

    always_comb begin
        exp_norm    = exp_sum_r;
        mant_norm   = prod_r[2*MANT_W-3:MANT_W-1];
        norm_result = 32'h0000_0000;
        if (prod_r[2*MANT_W-1]) begin
            exp_norm  = exp_sum_r + 10'sd1;
            mant_norm = prod_r[2*MANT_W-2:MANT_W];
        end
        if (exp_norm >= 10'sd255) begin
            norm_result = {sign_r, 8'hFF, 23'h0};
        end else if (exp_norm <= 10'sd0) begin
            norm_result = 32'h0000_0000;
        end else begin
            norm_result = {sign_r, exp_norm[7:0], mant_norm};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = is_special ? DONE : MULT;
            MULT: if (cnt_r == 5'(MANT_W - 1)) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r    <= 1'b0;
            exp_sum_r <= '0;
            mcand_r   <= '0;
            prod_r    <= '0;
            mplier_r  <= '0;
            cnt_r     <= '0;
            result_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_special) begin
                            result_r <= special_result;
                        end else begin
                            sign_r    <= operand_a[31] ^ operand_b[31];
                            exp_sum_r <= exp_sum_w;
                            mcand_r   <= {{MANT_W{1'b0}}, mant_a};
                            mplier_r  <= mant_b;
                            prod_r    <= '0;
                            cnt_r     <= '0;
                        end
                    end
                end
                MULT: begin
                    if (mplier_r[0]) prod_r <= prod_r + mcand_r;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + 5'd1;
                end
                NORM: result_r <= norm_result;
                default: ;
            endcase
        end
    end

    assign result = result_r;
    assign done   = (state == DONE);
    assign busy   = (state != IDLE);

endmodule
